// File: rtl/sa_pkg.sv
// Shared types and defaults for the systolic-array sequencing controller.
package sa_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_W,
    COMPUTE,
    DRAIN,
    DONE
  } sa_ctrl_state_t;

  localparam logic MODE_LOAD    = 1'b0;
  localparam logic MODE_COMPUTE = 1'b1;

  localparam int unsigned DEF_NUM_ROWS = 4;
  localparam int unsigned DEF_NUM_COLS = 4;
  localparam int unsigned DEF_VEC_W    = 8;

  // Activation issue to de-skewed output: one hop per row plus one per column.
  function automatic int unsigned pipe_lat(input int unsigned rows, input int unsigned cols);
    return rows + cols;
  endfunction

endpackage

// File: rtl/sa_controller_if.sv
// Scheduler/array-side signal bundle of sa_controller.
// o_perf_cycles exists only when SA_CTRL_PERF_EN is defined.
interface sa_controller_if #(
  parameter int unsigned VEC_W    = 8,
  parameter int unsigned NUM_ROWS = 4
);
  localparam int unsigned RA_W = $clog2(NUM_ROWS);

  logic              i_start;
  logic [VEC_W-1:0]  i_num_vecs;
  logic              i_acc;
  logic              o_busy;
  logic              o_done;
  logic              o_mode;
  logic              o_load_psum;
  logic              o_w_rd_en;
  logic [RA_W-1:0]   o_w_rd_addr;
  logic              o_act_rd_en;
  logic [VEC_W-1:0]  o_act_rd_addr;
  logic              o_psum_rd_en;
  logic              o_out_wr_en;
  logic [VEC_W-1:0]  o_out_wr_addr;
`ifdef SA_CTRL_PERF_EN
  logic [31:0]       o_perf_cycles;
`endif

  // master: tile scheduler side; slave: the controller.
  modport master (
`ifdef SA_CTRL_PERF_EN
    input  o_perf_cycles,
`endif
    output i_start, i_num_vecs, i_acc,
    input  o_busy, o_done, o_mode, o_load_psum, o_w_rd_en, o_w_rd_addr,
    input  o_act_rd_en, o_act_rd_addr, o_psum_rd_en, o_out_wr_en, o_out_wr_addr
  );

  modport slave (
`ifdef SA_CTRL_PERF_EN
    output o_perf_cycles,
`endif
    input  i_start, i_num_vecs, i_acc,
    output o_busy, o_done, o_mode, o_load_psum, o_w_rd_en, o_w_rd_addr,
    output o_act_rd_en, o_act_rd_addr, o_psum_rd_en, o_out_wr_en, o_out_wr_addr
  );

endinterface

// File: rtl/sa_ctrl_vld_pipe.sv
// Shift register tracking in-flight activation vectors {valid, index} up to the output buffer.
module sa_ctrl_vld_pipe #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned VEC_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_vld,
  input  logic [VEC_W-1:0] i_idx,
  output logic             o_vld,
  output logic [VEC_W-1:0] o_idx,
  output logic             o_empty
);

  logic [DEPTH-1:0] vld_q;
  logic [VEC_W-1:0] idx_q [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      for (int i = 0; i < DEPTH; i++) idx_q[i] <= '0;
    end else begin
      vld_q    <= {vld_q[DEPTH-2:0], i_vld};
      idx_q[0] <= i_idx;
      for (int i = 1; i < DEPTH; i++) idx_q[i] <= idx_q[i-1];
    end
  end

  assign o_vld   = vld_q[DEPTH-1];
  assign o_idx   = idx_q[DEPTH-1];
  // Empty once only the stage currently presenting a write (or nothing) remains.
  assign o_empty = ~|vld_q[DEPTH-2:0];

endmodule

// File: rtl/sa_controller.sv
// Tile sequencer for the weight-stationary systolic array: weight load, activation stream, drain.
// Define SA_CTRL_PERF_EN to add the o_perf_cycles busy-cycle counter.
//
// state   | meaning
// IDLE    | waiting for i_start; latches num_vecs/acc on accept
// LOAD_W  | NUM_ROWS cycles of weight reads, bottom row first
// COMPUTE | num_vecs cycles of activation (and optional psum) reads
// DRAIN   | wait for in-flight vectors to reach the output buffer
// DONE    | one-cycle o_done pulse
module sa_controller
  import sa_pkg::*;
#(
  parameter int unsigned NUM_ROWS = DEF_NUM_ROWS,
  parameter int unsigned NUM_COLS = DEF_NUM_COLS,
  parameter int unsigned PIPE_LAT = pipe_lat(NUM_ROWS, NUM_COLS),
  parameter int unsigned VEC_W    = DEF_VEC_W
) (
  input  logic           clk,
  input  logic           rst_n,
  sa_controller_if.slave bus
);

  localparam int unsigned     RA_W     = $clog2(NUM_ROWS);
  localparam logic [RA_W-1:0] LAST_ROW = RA_W'(NUM_ROWS - 1);

  sa_ctrl_state_t   state_q, state_d;
  logic [RA_W-1:0]  row_q, row_d;
  logic [VEC_W-1:0] nv_q, nv_d;
  logic [VEC_W-1:0] vrem_q, vrem_d;
  logic [VEC_W-1:0] vidx_q, vidx_d;
  logic             acc_q, acc_d;
  logic             start_acc;

  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             mode_q, mode_d;
  logic             w_en_q, w_en_d;
  logic [RA_W-1:0]  w_addr_q, w_addr_d;
  logic             act_en_q, act_en_d;
  logic [VEC_W-1:0] act_addr_q, act_addr_d;
  logic             psum_q, psum_d;

  logic             pipe_empty;
  logic             out_wr_en;
  logic [VEC_W-1:0] out_wr_addr;

  always_comb begin
    state_d   = state_q;
    row_d     = row_q;
    nv_d      = nv_q;
    vrem_d    = vrem_q;
    vidx_d    = vidx_q;
    acc_d     = acc_q;
    start_acc = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.i_start) begin
          start_acc = 1'b1;
          state_d   = LOAD_W;
          nv_d      = bus.i_num_vecs;
          acc_d     = bus.i_acc;
          row_d     = LAST_ROW;
        end
      end
      LOAD_W: begin
        if (row_q == '0) begin
          state_d = (nv_q == '0) ? DRAIN : COMPUTE;
          vrem_d  = nv_q - VEC_W'(1);
          vidx_d  = '0;
        end else begin
          row_d = row_q - RA_W'(1);
        end
      end
      COMPUTE: begin
        if (vrem_q == '0) begin
          state_d = DRAIN;
        end else begin
          vrem_d = vrem_q - VEC_W'(1);
          vidx_d = vidx_q + VEC_W'(1);
        end
      end
      DRAIN:   if (pipe_empty) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Outputs are decoded from the next state so the registered copies line up with state_q.
    busy_d     = (state_d != IDLE);
    done_d     = (state_d == DONE);
    mode_d     = (state_d == COMPUTE || state_d == DRAIN) ? MODE_COMPUTE : MODE_LOAD;
    w_en_d     = (state_d == LOAD_W);
    w_addr_d   = w_en_d ? row_d : '0;
    act_en_d   = (state_d == COMPUTE);
    act_addr_d = act_en_d ? vidx_d : '0;
    psum_d     = act_en_d & acc_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      row_q      <= '0;
      nv_q       <= '0;
      vrem_q     <= '0;
      vidx_q     <= '0;
      acc_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      mode_q     <= MODE_LOAD;
      w_en_q     <= 1'b0;
      w_addr_q   <= '0;
      act_en_q   <= 1'b0;
      act_addr_q <= '0;
      psum_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      row_q      <= row_d;
      nv_q       <= nv_d;
      vrem_q     <= vrem_d;
      vidx_q     <= vidx_d;
      acc_q      <= acc_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      mode_q     <= mode_d;
      w_en_q     <= w_en_d;
      w_addr_q   <= w_addr_d;
      act_en_q   <= act_en_d;
      act_addr_q <= act_addr_d;
      psum_q     <= psum_d;
    end
  end

  sa_ctrl_vld_pipe #(
    .DEPTH (PIPE_LAT),
    .VEC_W (VEC_W)
  ) u_vld_pipe (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_vld   (act_en_q),
    .i_idx   (act_addr_q),
    .o_vld   (out_wr_en),
    .o_idx   (out_wr_addr),
    .o_empty (pipe_empty)
  );

`ifdef SA_CTRL_PERF_EN
  logic [31:0] perf_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_q <= '0;
    end else if (start_acc) begin
      perf_q <= '0;
    end else if (state_q != IDLE && perf_q != '1) begin
      perf_q <= perf_q + 32'd1;
    end
  end

  assign bus.o_perf_cycles = perf_q;
`endif

  assign bus.o_busy        = busy_q;
  assign bus.o_done        = done_q;
  assign bus.o_mode        = mode_q;
  assign bus.o_load_psum   = psum_q;
  assign bus.o_w_rd_en     = w_en_q;
  assign bus.o_w_rd_addr   = w_addr_q;
  assign bus.o_act_rd_en   = act_en_q;
  assign bus.o_act_rd_addr = act_addr_q;
  assign bus.o_psum_rd_en  = psum_q;
  assign bus.o_out_wr_en   = out_wr_en;
  assign bus.o_out_wr_addr = out_wr_addr;

endmodule

// File: tb/tb_sa_controller.sv
// Self-checking bench for sa_controller against a closed-form per-tile timing model.
// Covers the o_perf_cycles counter when SA_CTRL_PERF_EN is defined.
module tb_sa_controller;

  localparam int R = 4;
  localparam int L = 8;

  logic clk;
  logic rst_n;

  sa_controller_if #(.VEC_W(8), .NUM_ROWS(4)) bus ();

  sa_controller #(.NUM_ROWS(4), .NUM_COLS(4), .PIPE_LAT(8), .VEC_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic       busy;
    logic       done;
    logic       mode;
    logic       w_en;
    logic [1:0] w_addr;
    logic       act_en;
    logic [7:0] act_addr;
    logic       psum;
    logic       wr_en;
    logic [7:0] wr_addr;
  } exp_t;

  // Posedges fall at 10k+5, so at a posedge (or just after) this is the edge index,
  // and at the following negedge it is the index of the cycle ending at the next edge.
  function automatic int cur();
    return int'($time / 10);
  endfunction

  function automatic int done_rel(input int n);
    return (n == 0) ? R + 2 : R + L + n + 1;
  endfunction

  function automatic exp_t model_out(input int rel, input int n, input bit acc);
    exp_t e;
    int   d;
    e = '0;
    d = done_rel(n);
    if (rel >= 1 && rel <= d) begin
      e.busy = 1'b1;
      e.done = (rel == d);
      e.mode = (rel >= R + 1 && rel <= d - 1);
      if (rel <= R) begin
        e.w_en   = 1'b1;
        e.w_addr = 2'(R - rel);
      end
      if (rel >= R + 1 && rel <= R + n) begin
        e.act_en   = 1'b1;
        e.act_addr = 8'(rel - R - 1);
        e.psum     = acc;
      end
      if (rel >= R + L + 1 && rel <= R + L + n) begin
        e.wr_en   = 1'b1;
        e.wr_addr = 8'(rel - R - L - 1);
      end
    end
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cur(), act, exp);
    end
  endtask

  // Reference tile tracker: acceptance decided from the rules, not from DUT state.
  bit tile_v   = 1'b0;
  int tile_e   = 0;
  int tile_n   = 0;
  bit tile_acc = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tile_v = 1'b0;
    end else if (bus.i_start && (!tile_v || cur() >= tile_e + done_rel(tile_n) + 1)) begin
      tile_v   = 1'b1;
      tile_e   = cur();
      tile_n   = int'(bus.i_num_vecs);
      tile_acc = bus.i_acc;
    end
  end

  always @(negedge clk) begin
    exp_t e;
    int   rel;
    int   perf;
    e    = '0;
    perf = 0;
    if (rst_n && tile_v) begin
      rel  = cur() - tile_e;
      e    = model_out(rel, tile_n, tile_acc);
      perf = (rel - 1 < done_rel(tile_n)) ? rel - 1 : done_rel(tile_n);
    end
    chk("busy",      32'(bus.o_busy),        32'(e.busy));
    chk("done",      32'(bus.o_done),        32'(e.done));
    chk("mode",      32'(bus.o_mode),        32'(e.mode));
    chk("load_psum", 32'(bus.o_load_psum),   32'(e.psum));
    chk("psum_rd",   32'(bus.o_psum_rd_en),  32'(e.psum));
    chk("w_rd_en",   32'(bus.o_w_rd_en),     32'(e.w_en));
    chk("w_rd_addr", 32'(bus.o_w_rd_addr),   32'(e.w_addr));
    chk("act_rd_en", 32'(bus.o_act_rd_en),   32'(e.act_en));
    chk("act_addr",  32'(bus.o_act_rd_addr), 32'(e.act_addr));
    chk("out_wr_en", 32'(bus.o_out_wr_en),   32'(e.wr_en));
    chk("out_addr",  32'(bus.o_out_wr_addr), 32'(e.wr_addr));
`ifdef SA_CTRL_PERF_EN
    chk("perf",      bus.o_perf_cycles,      32'(perf));
`endif
  end

  task automatic at_cycle(input int c);
    while (cur() < c) @(negedge clk);
  endtask

  task automatic start_tile(input int n, input bit acc, output int e);
    @(posedge clk); #1;
    bus.i_start    = 1'b1;
    bus.i_num_vecs = 8'(n);
    bus.i_acc      = acc;
    @(posedge clk); #1;
    e           = cur();
    bus.i_start = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int i;
    i = 0;
    @(negedge clk);
    while (bus.o_busy && i < budget) begin
      @(negedge clk);
      i++;
    end
    chk("idle_timeout", 32'(bus.o_busy), 32'd0);
  endtask

  initial begin
    int e;
    int done_at;
    rst_n          = 1'b0;
    bus.i_start    = 1'b0;
    bus.i_num_vecs = '0;
    bus.i_acc      = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Basic tile, num_vecs=3, acc=0.
    start_tile(3, 1'b0, e);
    at_cycle(e + 1);  chk("lit_w_addr_c1",  32'(bus.o_w_rd_addr), 32'd3);
    at_cycle(e + 4);  chk("lit_w_addr_c4",  32'(bus.o_w_rd_addr), 32'd0);
    at_cycle(e + 7);  chk("lit_act_c7",     32'(bus.o_act_rd_addr), 32'd2);
    at_cycle(e + 12); chk("lit_wr_c12",     32'(bus.o_out_wr_en), 32'd0);
    at_cycle(e + 13); chk("lit_wr_c13",     32'(bus.o_out_wr_en), 32'd1);
    at_cycle(e + 15); chk("lit_wraddr_c15", 32'(bus.o_out_wr_addr), 32'd2);
    at_cycle(e + 16); chk("lit_done_c16",   32'(bus.o_done), 32'd1);
`ifdef SA_CTRL_PERF_EN
    at_cycle(e + 17); chk("lit_perf_c17",   bus.o_perf_cycles, 32'd16);
    at_cycle(e + 20); chk("lit_perf_hold",  bus.o_perf_cycles, 32'd16);
`endif
    at_cycle(e + 17); chk("lit_busy_c17",   32'(bus.o_busy), 32'd0);
    wait_idle(50);

    // Accumulate, num_vecs=2.
    start_tile(2, 1'b1, e);
    at_cycle(e + 4); chk("lit_psum_c4", 32'(bus.o_load_psum), 32'd0);
    at_cycle(e + 5); chk("lit_psum_c5", 32'(bus.o_psum_rd_en), 32'd1);
    at_cycle(e + 7); chk("lit_psum_c7", 32'(bus.o_load_psum), 32'd0);
    wait_idle(50);

    // Empty tile.
    start_tile(0, 1'b1, e);
    at_cycle(e + 5); chk("lit_nv0_drain", 32'(bus.o_mode), 32'd1);
    at_cycle(e + 6); chk("lit_nv0_done",  32'(bus.o_done), 32'd1);
    wait_idle(50);

    // Start held high; num_vecs changes mid-tile and must not be re-latched.
    @(posedge clk); #1;
    bus.i_start    = 1'b1;
    bus.i_num_vecs = 8'd3;
    bus.i_acc      = 1'b0;
    @(posedge clk); #1;
    e              = cur();
    bus.i_num_vecs = 8'd5;
    at_cycle(e + 16); chk("lit_held_done", 32'(bus.o_done), 32'd1);
    at_cycle(e + 18); chk("lit_held_2nd",  32'(bus.o_w_rd_en), 32'd1);
    @(posedge clk); #1;
    bus.i_start = 1'b0;
    wait_idle(60);

    // Reset asserted on cycle 9 of a tile, then a normal tile.
    start_tile(3, 1'b1, e);
    at_cycle(e + 8);
    @(posedge clk); #1;
    rst_n = 1'b0;
    at_cycle(e + 9); chk("lit_rst_busy", 32'(bus.o_busy), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    start_tile(1, 1'b0, e);
    at_cycle(e + 14); chk("lit_after_rst_done", 32'(bus.o_done), 32'd1);
    wait_idle(50);

    // Randomized start requests, including while busy.
    for (int i = 0; i < 600; i++) begin
      @(posedge clk); #1;
      bus.i_start    = ($urandom_range(0, 3) == 0);
      bus.i_num_vecs = 8'($urandom_range(0, 12));
      bus.i_acc      = 1'($urandom_range(0, 1));
    end
    @(posedge clk); #1;
    bus.i_start = 1'b0;
    wait_idle(100);

    // Maximum tile length.
    start_tile(255, 1'b1, e);
    done_at = -1;
    for (int i = 0; i < 400 && done_at < 0; i++) begin
      @(negedge clk);
      if (bus.o_done === 1'b1) done_at = cur();
    end
    chk("lit_max_done_cycle", 32'(done_at - e), 32'd268);
    wait_idle(50);

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sa_controller.md
Name: sa_controller

Overview:
- Sequencing FSM for the weight-stationary systolic compute array.
- Runs one tile per start: weight pre-load (mode 0), then activation streaming (mode 1), then drain of in-flight results.
- Drives array mode and psum-load mux, buffer read strobes/addresses, and output-buffer write strobes; raises done.
- Sits between the tile scheduler (start/done) and the array plus its weight/act/psum/output buffers. Skew/de-skew registers live outside this block.

Parameters:
- NUM_ROWS, 4, array rows; weight pre-load length in cycles.
- NUM_COLS, 4, array columns.
- PIPE_LAT, NUM_ROWS+NUM_COLS, cycles from activation-vector issue to its de-skewed output being valid at the output buffer.
- VEC_W, 8, width of vector count and addresses.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- i_start  in  1  tile start request; sampled only in IDLE
- i_num_vecs  in  VEC_W  activation vectors in tile; latched on accepted start
- i_acc  in  1  accumulate onto stored psums; latched on accepted start
- o_busy  out  1  high in every state except IDLE
- o_done  out  1  single-cycle pulse at tile completion
- o_mode  out  1  array mode: 0 = weight pre-load, 1 = compute
- o_load_psum  out  1  array psum-load mux select
- o_w_rd_en  out  1  weight buffer read enable
- o_w_rd_addr  out  $clog2(NUM_ROWS)  weight row address
- o_act_rd_en  out  1  activation buffer read enable
- o_act_rd_addr  out  VEC_W  activation vector index
- o_psum_rd_en  out  1  psum buffer read enable
- o_out_wr_en  out  1  output buffer write enable
- o_out_wr_addr  out  VEC_W  output vector index

Behaviour:
- All outputs are registered. On reset every output is 0, the state is IDLE and all counters clear.
- Reset asserted mid-tile aborts the tile immediately. No o_done is produced.
- States: IDLE, LOAD_W, COMPUTE, DRAIN, DONE.
- IDLE
  - When i_start=1 on an edge: latch i_num_vecs and i_acc, go to LOAD_W.
  - i_start is ignored in all other states.
- LOAD_W
  - Lasts exactly NUM_ROWS cycles. o_mode=0, o_load_psum=0, o_w_rd_en=1.
  - o_w_rd_addr = NUM_ROWS-1-k on load cycle k, so the bottom row's weights enter first.
  - Next state: COMPUTE, or DRAIN if num_vecs==0.
- COMPUTE
  - Lasts num_vecs cycles. o_mode=1, o_act_rd_en=1, o_act_rd_addr=v for v=0..num_vecs-1.
  - o_load_psum = o_psum_rd_en = latched acc.
- DRAIN
  - o_mode stays 1; o_load_psum, o_act_rd_en and o_psum_rd_en are 0.
  - Exits to DONE once the last scheduled output write has issued, or immediately if num_vecs==0.
- DONE: one cycle with o_done=1, o_mode=0, then IDLE. A start on that edge is ignored; it is accepted the next cycle.
- Output timing: o_out_wr_en=1 and o_out_wr_addr=v exactly PIPE_LAT cycles after the cycle vector v was issued. Writes arrive in order, one per cycle, with no gaps.
- Writes may overlap the end of COMPUTE. They never issue outside COMPUTE or DRAIN.
- num_vecs = 2^VEC_W-1 (maximum) must complete without counter wrap.

Optional Feature:
- Macro: SA_CTRL_PERF_EN.
- When defined:
  - Adds output o_perf_cycles (32 bits).
  - The counter clears on an accepted start and increments every cycle the block is not in IDLE.
  - It holds its value after DONE until the next start.
  - It saturates at all-ones and resets to 0.
- When undefined: the port and counter are absent. All other behaviour is identical.

Decomposition:
- Shared package sa_pkg holds:
  - typedef enum sa_ctrl_state_t {IDLE, LOAD_W, COMPUTE, DRAIN, DONE};
  - the PIPE_LAT default expression;
  - the mode encodings MODE_LOAD=0 and MODE_COMPUTE=1.
- One sub-module, sa_ctrl_vld_pipe: a PIPE_LAT-deep shift register carrying {valid, VEC_W index}.
  - Input: issue strobe plus index. Output: o_out_wr_en/o_out_wr_addr.
  - Exposes an empty flag that gates the DRAIN to DONE transition.

Test Plan (NUM_ROWS=4, NUM_COLS=4, PIPE_LAT=8, start accepted at edge 0):
- Basic tile, num_vecs=3, acc=0:
  - LOAD_W cycles 1-4 with w_rd_addr 3,2,1,0.
  - act_rd_addr 0,1,2 on cycles 5-7.
  - out_wr_addr 0,1,2 on cycles 13-15.
  - o_done on cycle 16; busy low on cycle 17.
- acc=1, num_vecs=2: o_load_psum and o_psum_rd_en high on cycles 5-6 only, low during LOAD_W and DRAIN.
- num_vecs=0: LOAD_W cycles 1-4, DRAIN cycle 5, o_done cycle 6, zero output writes.
- i_start held high throughout a num_vecs=3 tile: no re-latch while busy; a second tile is accepted on cycle 17.
- rst_n pulsed low on cycle 9 of a num_vecs=3 tile: all outputs 0 immediately, no o_done and no further writes; a new start then runs normally.
- With SA_CTRL_PERF_EN, num_vecs=3: o_perf_cycles=16 after DONE, holding until the next start.
